// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the memory data port between the pipeline MEM stage (p_*) and the
//   host/loader (h_*). A request is granted combinationally in IDLE or RESP,
//   latched on the grant edge, driven onto the memory port for one cycle
//   (ACCESS), and answered one cycle later (RESP) with rd and an
//   out-of-range flag.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   p_req/p_we/p_addr/p_wd          pipeline request
//   p_gnt/p_rvalid/p_err            pipeline grant, response valid, range error
//   h_req/h_we/h_addr/h_wd          host request
//   h_gnt/h_rvalid/h_err            host grant, response valid, range error
//   rd                              response read data (shared)
//   mem_we/mem_a/mem_wd             memory data port command
//   mem_rd                          memory read data, valid the cycle after mem_a
module dmem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int RAMSIZE      = 128,
    parameter int NSEG         = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_req,
    input  logic             p_we,
    input  logic [WIDTH-1:0] p_addr,
    input  logic [WIDTH-1:0] p_wd,
    output logic             p_gnt,
    output logic             p_rvalid,
    output logic             p_err,
    input  logic             h_req,
    input  logic             h_we,
    input  logic [WIDTH-1:0] h_addr,
    input  logic [WIDTH-1:0] h_wd,
    output logic             h_gnt,
    output logic             h_rvalid,
    output logic             h_err,
    output logic [WIDTH-1:0] rd,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam int               CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
    localparam logic [WIDTH-1:0] ADDR_END = WIDTH'(NSEG * RAMSIZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] wait_cnt_q;
    logic             owner_p1;      // 0 = pipeline, 1 = host
    logic             we_p1;
    logic [WIDTH-1:0] addr_p1;
    logic [WIDTH-1:0] wd_p1;
    logic             in_range_p1;

    logic             grant_win;
    logic             host_win;
    logic             grant_any;
    logic             sel_we;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wd;

    // Arbitration: pipeline has priority unless the host has waited long enough.
    assign grant_win = (state_q == IDLE) || (state_q == RESP);
    assign host_win  = h_req && (!p_req || (wait_cnt_q >= CNT_MAX));
    assign grant_any = grant_win && (p_req || h_req);
    assign sel_we    = host_win ? h_we   : p_we;
    assign sel_addr  = host_win ? h_addr : p_addr;
    assign sel_wd    = host_win ? h_wd   : p_wd;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant_any ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = grant_any ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Host starvation counter: counts consecutive ungranted host request cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (!h_req || (grant_win && host_win)) begin
            wait_cnt_q <= '0;
        end else if (wait_cnt_q < CNT_MAX) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    // Grant edge -> stage 1: latch the winning request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_p1 <= 1'b0;
        end else if (grant_any) begin
            owner_p1 <= host_win;
        end
    end

    // Payload registers carry no reset; they are only observed when the
    // state machine says they hold a live request.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            we_p1       <= sel_we;
            addr_p1     <= sel_addr;
            wd_p1       <= sel_wd;
            in_range_p1 <= (sel_addr < ADDR_END);
        end
    end

    // Output logic
    always_comb begin
        p_gnt    = 1'b0;
        h_gnt    = 1'b0;
        p_rvalid = 1'b0;
        h_rvalid = 1'b0;
        p_err    = 1'b0;
        h_err    = 1'b0;
        rd       = '0;
        mem_we   = 1'b0;
        mem_a    = '0;
        mem_wd   = '0;

        if (grant_win) begin
            h_gnt = host_win;
            p_gnt = p_req && !host_win;
        end

        case (state_q)
            ACCESS: begin
                mem_a  = addr_p1;
                mem_wd = wd_p1;
                // Out-of-range writes run the full sequence but never reach memory.
                mem_we = we_p1 && in_range_p1;
            end
            RESP: begin
                if (owner_p1) begin
                    h_rvalid = 1'b1;
                    h_err    = !in_range_p1;
                end else begin
                    p_rvalid = 1'b1;
                    p_err    = !in_range_p1;
                end
                if (!we_p1 && in_range_p1) begin
                    rd = mem_rd;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int WIDTH   = 32;
    localparam int RAMSIZE = 128;
    localparam int NSEG    = 6;
    localparam int STARVE  = 4;
    localparam int TOP     = NSEG * RAMSIZE;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_req, p_we, h_req, h_we;
    logic [31:0] p_addr, p_wd, h_addr, h_wd;
    logic        p_gnt, p_rvalid, p_err, h_gnt, h_rvalid, h_err;
    logic [31:0] rd, mem_a, mem_wd, mem_rd;
    logic        mem_we;

    dmem_arbiter #(
        .WIDTH(WIDTH), .RAMSIZE(RAMSIZE), .NSEG(NSEG), .STARVE_LIMIT(STARVE)
    ) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wd(p_wd),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_err(p_err),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wd(h_wd),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_err(h_err),
        .rd(rd), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Initial memory content, a fixed scramble of the address.
    function automatic logic [31:0] seed(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Memory emulation: synchronous read, stored XOR seed so unwritten words read as seed(a).
    bit [31:0] mem_arr [TOP];
    always @(posedge clk) begin
        if (mem_we && mem_a < TOP) mem_arr[mem_a] <= mem_wd ^ seed(mem_a);
        mem_rd <= (mem_a < TOP) ? (mem_arr[mem_a] ^ seed(mem_a)) : 32'hBAD0BAD0;
    end

    // Reference model state
    typedef struct { int due; bit owner; logic we; logic [31:0] addr; logic [31:0] wd; } acc_t;
    typedef struct { int due; bit owner; logic [31:0] rdata; bit err; } rsp_t;
    acc_t acc_q[$];
    rsp_t rsp_q[$];
    logic [31:0] model_mem [int];
    int last_gnt  = -100;
    int host_wait = 0;

    function automatic logic [31:0] mref(input logic [31:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return seed(a);
    endfunction

    // Model: predicts grants and memory-port activity, feeds the response scoreboard.
    always @(negedge clk) begin
        acc_t a;
        rsp_t r;
        bit   allow, exp_h, exp_p, inr;
        if (reset) begin
            acc_q.delete();
            last_gnt  = -100;
            host_wait = 0;
            chk("reset_outputs", {27'd0, p_gnt, h_gnt, mem_we, mem_a != 0, mem_wd != 0}, 32'd0);
        end else begin
            if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
                a   = acc_q.pop_front();
                inr = (a.addr < TOP);
                chk("mem_we", mem_we, a.we && inr);
                chk("mem_a", mem_a, a.addr);
                chk("mem_wd", mem_wd, a.wd);
                r.due   = cyc + 1;
                r.owner = a.owner;
                r.err   = !inr;
                r.rdata = (!a.we && inr) ? mref(a.addr) : 32'd0;
                if (a.we && inr) model_mem[int'(a.addr)] = a.wd;
                rsp_q.push_back(r);
            end else begin
                chk("mem_port_idle", {29'd0, mem_we, mem_a != 0, mem_wd != 0}, 32'd0);
            end

            allow = (cyc - last_gnt) >= 2;
            exp_h = allow && h_req && (!p_req || host_wait >= STARVE);
            exp_p = allow && p_req && !exp_h;
            chk("p_gnt", p_gnt, exp_p);
            chk("h_gnt", h_gnt, exp_h);
            if (exp_h || exp_p) begin
                last_gnt = cyc;
                a.due   = cyc + 1;
                a.owner = exp_h;
                a.we    = exp_h ? h_we   : p_we;
                a.addr  = exp_h ? h_addr : p_addr;
                a.wd    = exp_h ? h_wd   : p_wd;
                acc_q.push_back(a);
            end
            if (exp_h || !h_req) host_wait = 0;
            else if (host_wait < STARVE) host_wait++;
        end
    end

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        rsp_t r;
        if (reset) begin
            rsp_q.delete();
            chk("reset_resp", {27'd0, p_rvalid, h_rvalid, p_err, h_err, rd != 0}, 32'd0);
        end else if (p_rvalid || h_rvalid) begin
            if (rsp_q.size() == 0 || rsp_q[0].due != cyc) begin
                chk("unexpected_rvalid", {30'd0, p_rvalid, h_rvalid}, 32'd0);
            end else begin
                r = rsp_q.pop_front();
                chk("p_rvalid", p_rvalid, !r.owner);
                chk("h_rvalid", h_rvalid, r.owner);
                chk("rd", rd, r.rdata);
                chk("p_err", p_err, r.owner ? 1'b0 : r.err);
                chk("h_err", h_err, r.owner ? r.err : 1'b0);
            end
        end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            chk("missing_rvalid", {30'd0, p_rvalid, h_rvalid}, r.owner ? 32'd1 : 32'd2);
        end else begin
            chk("idle_resp", {29'd0, p_err, h_err, rd != 0}, 32'd0);
        end
    end

    task automatic p_access(input logic we, input logic [31:0] a, input logic [31:0] d);
        bit got = 0;
        p_we = we; p_addr = a; p_wd = d; p_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (p_gnt) begin got = 1; break; end
            @(posedge clk); #1;
        end
        if (!got) chk("p_gnt_timeout", p_gnt, 1'b1);
        @(posedge clk); #1;
        p_req = 1'b0;
    endtask

    task automatic h_access(input logic we, input logic [31:0] a, input logic [31:0] d);
        bit got = 0;
        h_we = we; h_addr = a; h_wd = d; h_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (h_gnt) begin got = 1; break; end
            @(posedge clk); #1;
        end
        if (!got) chk("h_gnt_timeout", h_gnt, 1'b1);
        @(posedge clk); #1;
        h_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int sel = $urandom_range(0, 9);
        if (sel == 0) return 32'hFFFF_FFFF;
        if (sel == 1) return 32'($urandom_range(TOP - 2, TOP + 2));
        if (sel == 2) return 32'(TOP - 1);
        return 32'($urandom_range(0, TOP - 1));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        p_req = 0; p_we = 0; p_addr = 0; p_wd = 0;
        h_req = 0; h_we = 0; h_addr = 0; h_wd = 0;
        idle(3);
        reset = 1'b0;
        idle(1);

        // Pipeline write then read back
        p_access(1'b1, 32'd5, 32'hDEAD_BEEF);
        p_access(1'b0, 32'd5, 32'd0);
        idle(3);

        // Contention: both requesters held, host must win after starving
        fork
            begin
                for (int k = 0; k < 4; k++) p_access(1'b0, 32'(k * 7), 32'd0);
            end
            h_access(1'b0, 32'd100, 32'd0);
        join
        idle(3);

        // Range boundaries from the host
        h_access(1'b0, 32'(TOP - 1), 32'd0);
        h_access(1'b1, 32'(TOP), 32'h1111_2222);
        h_access(1'b1, 32'hFFFF_FFFF, 32'h3333_4444);
        h_access(1'b0, 32'(TOP), 32'd0);
        idle(2);

        // Back-to-back pipeline reads
        p_access(1'b0, 32'd0, 32'd0);
        p_access(1'b0, 32'd128, 32'd0);
        p_access(1'b0, 32'd640, 32'd0);
        idle(3);

        // Reset while a pipeline write is on the memory port
        p_access(1'b1, 32'd10, 32'h1234_5678);
        #1 reset = 1'b1;
        #1 chk("mem_we_on_reset", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(3);
        p_access(1'b0, 32'd10, 32'd0);
        idle(2);

        // Randomised traffic from both sides
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    idle($urandom_range(0, 3));
                    p_access(1'($urandom_range(0, 1)), rand_addr(), $urandom);
                end
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    idle($urandom_range(0, 3));
                    h_access(1'($urandom_range(0, 1)), rand_addr(), $urandom);
                end
            end
        join

        idle(5);
        chk("drain", 32'(acc_q.size() + rsp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-segment port of the segmented memory between two requesters: the pipeline MEM stage (port p_*) and the host/loader interface (port h_*). The host interface loads data and reads back results.
- Arbitrates between them, latches the winning request, and drives the memory data port for exactly one cycle.
- Returns read data with a valid pulse, and flags addresses beyond the last data segment as errors.
- Sits between the MEM stage / host loader and the memory's data port (we, a2, wd, rd2).

Parameters:
- WIDTH, 32, data and address width.
- RAMSIZE, 128, words per data segment.
- NSEG, 6, number of data segments. Valid addresses are 0 .. NSEG*RAMSIZE-1.
- STARVE_LIMIT, 4, consecutive host wait cycles before the host overrides pipeline priority.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- p_req  in  1  pipeline access request
- p_we  in  1  pipeline write (1) / read (0)
- p_addr  in  WIDTH  pipeline address
- p_wd  in  WIDTH  pipeline write data
- p_gnt  out  1  pipeline request accepted this cycle
- p_rvalid  out  1  pipeline response valid
- p_err  out  1  pipeline response is out-of-range
- h_req, h_we, h_addr, h_wd, h_gnt, h_rvalid, h_err  same as the p_* ports, for the host requester
- rd  out  WIDTH  response read data (shared by both requesters)
- mem_we  out  1  memory data-port write enable
- mem_a  out  WIDTH  memory data-port address
- mem_wd  out  WIDTH  memory data-port write data
- mem_rd  in  WIDTH  memory data-port read data; synchronous, valid the cycle after mem_a is presented

Behaviour:
- Clock and reset: clk, reset, asynchronous and active-high (decided).
- Reset state: all outputs are 0; state=IDLE; host wait counter=0; owner=pipeline.
- States:
  - IDLE: no access in flight.
  - ACCESS: the latched request is driven onto the memory port.
  - RESP: the response is returned to the owner.
- Grant window:
  - Grants occur only in IDLE or RESP.
  - At most one of p_gnt/h_gnt is high in any cycle.
  - Each grant is a combinational single-cycle pulse in the cycle the request is seen.
- Arbitration:
  - The pipeline wins by default.
  - The host wins if only h_req is high, or if both are high and the wait counter >= STARVE_LIMIT.
- Host wait counter:
  - Increments each cycle that h_req=1 and h_gnt=0.
  - Saturates at STARVE_LIMIT.
  - Clears on h_gnt, and when h_req=0.
- On the grant edge, the arbiter latches we, addr, wd and owner, and sets in_range = (addr < NSEG*RAMSIZE) as an unsigned compare. The state moves to ACCESS.
- Requester rule: hold req, we, addr and wd stable until gnt is seen. Inputs that change before the grant are not checked.
- ACCESS:
  - mem_a = latched addr; mem_wd = latched wd; mem_we = latched we AND in_range.
  - The state moves to RESP unconditionally.
- Outside ACCESS, mem_a, mem_wd and mem_we are 0.
- RESP:
  - The owner's rvalid=1 for one cycle; the other requester's rvalid stays 0.
  - Read, in range: rd = mem_rd.
  - Write, or out of range: rd = 0.
  - Owner's err = NOT in_range.
  - Next state: ACCESS if a new grant is issued this cycle, else IDLE.
- Outside RESP, rd=0 and both err=0.
- Latency: grant cycle N -> memory access cycle N+1 -> response cycle N+2. Sustained throughput is one access per 2 cycles.
- Out-of-range access: no memory write is issued (mem_we stays 0), but the full 3-cycle sequence still runs.
- Boundaries:
  - Address NSEG*RAMSIZE-1 is valid.
  - Address NSEG*RAMSIZE and any higher address (including 0xFFFFFFFF) give err=1.
- Simultaneous events: both requests in RESP follow the normal arbitration rules. A grant in RESP never suppresses the current response.
- Reset mid-operation:
  - The state returns to IDLE asynchronously.
  - mem_we drops immediately, so no write is committed on the next edge.
  - Any pending response is discarded; the requester must re-request.

Test Plan:
- Pipeline write 0xDEADBEEF to addr 5, then read addr 5. Required: p_gnt in cycle 0; mem_we=1, mem_a=5 in cycle 1; p_rvalid in cycle 2; the read response returns rd=0xDEADBEEF with p_err=0.
- Both p_req and h_req held continuously. Required: the pipeline wins the first grants; once the wait counter reaches 4, the host wins the next grant; then pipeline priority resumes. Neither gnt is ever high in the same cycle as the other.
- Host read at addr 767 (NSEG*RAMSIZE-1), then host write at addr 768. Required: addr 767 gives h_err=0; addr 768 gives h_err=1, rd=0 and mem_we=0 throughout.
- Back-to-back pipeline reads at addrs 0, 128, 640. Required: grants in cycles 0/2/4; responses in cycles 2/4/6; each response carries the mem_rd of its own address.
- Reset asserted during ACCESS of a pipeline write. Required: mem_we falls in the same cycle, no memory write occurs, no p_rvalid is issued, and all outputs are 0 until a new request arrives.
